// File: rtl/fwpit_sched_pkg.sv
// Shared types and constants for the fwpit_sched PIT initiator / timer multiplexer.
package fwpit_sched_pkg;

  typedef enum logic [2:0] {
    S_INIT_MOD,
    S_INIT_CTRL,
    S_IDLE,
    S_ACK,
    S_TICK,
    S_CFG_MOD,
    S_CFG_CTRL
  } state_e;

  localparam logic [3:0]  WB_SEL         = 4'hF;
  localparam logic        WB_WE          = 1'b1;

  localparam logic [2:0]  DEF_MOD_ADDR   = 3'd1;
  localparam logic [2:0]  DEF_CTRL_ADDR  = 3'd0;
  localparam logic [31:0] DEF_MOD_INIT   = 32'd1000;
  localparam logic [31:0] DEF_CTRL_INIT  = 32'h0000_000B;
  localparam logic [31:0] DEF_CTRL_ACK   = 32'h0000_000F;

endpackage

// File: rtl/fwpit_sched_chan.sv
// One virtual timer channel: tick counter, latched period, periodic flag, expiry flop.
module fwpit_sched_chan
  import fwpit_sched_pkg::*;
#(
  parameter int unsigned TW = 16
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          tick_i,
  input  logic          load_i,
  input  logic [TW-1:0] period_i,
  input  logic          periodic_i,
  output logic          active_o,
  output logic          expire_o
);

  logic [TW-1:0] count_q;
  logic [TW-1:0] period_q;
  logic          periodic_q;
  logic          active_q;
  logic          expire_q;

  // Load/cancel has priority over a tick landing in the same cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q    <= '0;
      period_q   <= '0;
      periodic_q <= 1'b0;
      active_q   <= 1'b0;
      expire_q   <= 1'b0;
    end else begin
      expire_q <= 1'b0;
      if (load_i) begin
        if (period_i == '0) begin
          active_q <= 1'b0;
        end else begin
          count_q    <= period_i;
          period_q   <= period_i;
          periodic_q <= periodic_i;
          active_q   <= 1'b1;
        end
      end else if (tick_i && active_q) begin
        if (count_q == TW'(1)) begin
          expire_q <= 1'b1;
          if (periodic_q) begin
            count_q <= period_q;
          end else begin
            active_q <= 1'b0;
          end
        end else begin
          count_q <= count_q - TW'(1);
        end
      end
    end
  end

  assign active_o = active_q;
  assign expire_o = expire_q;

endmodule

// File: rtl/fwpit_sched.sv
// PIT Wishbone initiator plus N_CH virtual software timers driven by the PIT tick.
// Optional FWPIT_SCHED_TICKCNT_EN adds tick_count / tick_overrun outputs.
module fwpit_sched
  import fwpit_sched_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned TW        = 16,
  parameter logic [2:0]  MOD_ADDR  = DEF_MOD_ADDR,
  parameter logic [2:0]  CTRL_ADDR = DEF_CTRL_ADDR,
  parameter logic [31:0] MOD_INIT  = DEF_MOD_INIT,
  parameter logic [31:0] CTRL_INIT = DEF_CTRL_INIT,
  parameter logic [31:0] CTRL_ACK  = DEF_CTRL_ACK
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic [2:0]         pit_adr,
  output logic [31:0]        pit_dat_w,
  input  logic [31:0]        pit_dat_r,
  output logic               pit_cyc,
  output logic               pit_stb,
  output logic               pit_we,
  output logic [3:0]         pit_sel,
  input  logic               pit_ack,
  input  logic               pit_irq,
  input  logic               cfg_req,
  input  logic [31:0]        cfg_mod,
  output logic               cfg_ack,
  output logic               ready,
  input  logic [N_CH-1:0]    ch_load,
  input  logic [N_CH*TW-1:0] ch_period,
  input  logic [N_CH-1:0]    ch_periodic,
  output logic [N_CH-1:0]    ch_active,
`ifdef FWPIT_SCHED_TICKCNT_EN
  output logic [31:0]        tick_count,
  output logic               tick_overrun,
`endif
  output logic [N_CH-1:0]    ch_expire
);

  state_e      state_q, state_d;
  logic        hold_q, hold_d;
  logic [31:0] mod_q, mod_d;
  logic        ready_q;
  logic        cfg_ack_q;
  logic        wr_en;
  logic [2:0]  wr_adr;
  logic [31:0] wr_dat;
  logic        tick;

  logic unused_dat_r;
  assign unused_dat_r = ^pit_dat_r;

  // hold_q forces one idle bus cycle between chained writes and keeps the bus quiet in reset.
  always_comb begin
    state_d = state_q;
    hold_d  = 1'b0;
    mod_d   = mod_q;
    wr_en   = 1'b0;
    wr_adr  = '0;
    wr_dat  = '0;
    unique case (state_q)
      S_INIT_MOD: begin
        wr_en  = !hold_q;
        wr_adr = MOD_ADDR;
        wr_dat = MOD_INIT;
        if (wr_en && pit_ack) begin
          state_d = S_INIT_CTRL;
          hold_d  = 1'b1;
        end
      end
      S_INIT_CTRL: begin
        wr_en  = !hold_q;
        wr_adr = CTRL_ADDR;
        wr_dat = CTRL_INIT;
        if (wr_en && pit_ack) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (pit_irq) begin
          state_d = S_ACK;
        end else if (cfg_req && !cfg_ack_q) begin
          mod_d   = cfg_mod;
          state_d = S_CFG_MOD;
        end
      end
      S_ACK: begin
        wr_en  = !hold_q;
        wr_adr = CTRL_ADDR;
        wr_dat = CTRL_ACK;
        if (wr_en && pit_ack) state_d = S_TICK;
      end
      S_TICK: state_d = S_IDLE;
      S_CFG_MOD: begin
        wr_en  = !hold_q;
        wr_adr = MOD_ADDR;
        wr_dat = mod_q;
        if (wr_en && pit_ack) begin
          state_d = S_CFG_CTRL;
          hold_d  = 1'b1;
        end
      end
      S_CFG_CTRL: begin
        wr_en  = !hold_q;
        wr_adr = CTRL_ADDR;
        wr_dat = CTRL_INIT;
        if (wr_en && pit_ack) state_d = S_IDLE;
      end
      default: state_d = S_INIT_MOD;
    endcase
    if (!wr_en) begin
      wr_adr = '0;
      wr_dat = '0;
    end
  end

  // FSM state, bus-quiet flag, latched modulo and status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_INIT_MOD;
      hold_q    <= 1'b1;
      mod_q     <= '0;
      ready_q   <= 1'b0;
      cfg_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      mod_q     <= mod_d;
      ready_q   <= ready_q | ((state_q == S_INIT_CTRL) && wr_en && pit_ack);
      cfg_ack_q <= (state_q == S_CFG_CTRL) && wr_en && pit_ack;
    end
  end

  assign pit_cyc   = wr_en;
  assign pit_stb   = wr_en;
  assign pit_we    = wr_en & WB_WE;
  assign pit_sel   = wr_en ? WB_SEL : '0;
  assign pit_adr   = wr_adr;
  assign pit_dat_w = wr_dat;
  assign ready     = ready_q;
  assign cfg_ack   = cfg_ack_q;

  assign tick = (state_q == S_TICK);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    fwpit_sched_chan #(.TW(TW)) u_chan (
      .clk_i      (clock),
      .rst_n_i    (reset_n),
      .tick_i     (tick),
      .load_i     (ch_load[g]),
      .period_i   (ch_period[g*TW +: TW]),
      .periodic_i (ch_periodic[g]),
      .active_o   (ch_active[g]),
      .expire_o   (ch_expire[g])
    );
  end

`ifdef FWPIT_SCHED_TICKCNT_EN
  logic [31:0] tick_cnt_q;
  logic        tick_exit_q;
  logic        overrun_q;

  // Tick counter; overrun flags an IRQ still high the cycle after a tick was serviced.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q  <= '0;
      tick_exit_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (tick) tick_cnt_q <= tick_cnt_q + 32'd1;
      tick_exit_q <= tick;
      if (tick_exit_q && pit_irq) overrun_q <= 1'b1;
    end
  end

  assign tick_count   = tick_cnt_q;
  assign tick_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_fwpit_sched.sv
// Self-checking bench for fwpit_sched: WB slave model with scoreboard, channel table, corner sequences.
module tb_fwpit_sched;

  localparam int N_CH = 4;
  localparam int TW   = 16;

  logic               clock;
  logic               reset_n;
  logic [2:0]         pit_adr;
  logic [31:0]        pit_dat_w;
  logic [31:0]        pit_dat_r;
  logic               pit_cyc;
  logic               pit_stb;
  logic               pit_we;
  logic [3:0]         pit_sel;
  logic               pit_ack;
  logic               pit_irq;
  logic               cfg_req;
  logic [31:0]        cfg_mod;
  logic               cfg_ack;
  logic               ready;
  logic [N_CH-1:0]    ch_load;
  logic [N_CH*TW-1:0] ch_period;
  logic [N_CH-1:0]    ch_periodic;
  logic [N_CH-1:0]    ch_active;
  logic [N_CH-1:0]    ch_expire;
`ifdef FWPIT_SCHED_TICKCNT_EN
  logic [31:0]        tick_count;
  logic               tick_overrun;
`endif

  fwpit_sched #(.N_CH(N_CH), .TW(TW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pit_adr     (pit_adr),
    .pit_dat_w   (pit_dat_w),
    .pit_dat_r   (pit_dat_r),
    .pit_cyc     (pit_cyc),
    .pit_stb     (pit_stb),
    .pit_we      (pit_we),
    .pit_sel     (pit_sel),
    .pit_ack     (pit_ack),
    .pit_irq     (pit_irq),
    .cfg_req     (cfg_req),
    .cfg_mod     (cfg_mod),
    .cfg_ack     (cfg_ack),
    .ready       (ready),
    .ch_load     (ch_load),
    .ch_period   (ch_period),
    .ch_periodic (ch_periodic),
    .ch_active   (ch_active),
`ifdef FWPIT_SCHED_TICKCNT_EN
    .tick_count  (tick_count),
    .tick_overrun(tick_overrun),
`endif
    .ch_expire   (ch_expire)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [2:0]  adr;
    logic [31:0] dat;
  } wr_t;

  typedef struct {
    int ch;
    int period;
    bit periodic;
    int n_irq;
    int exp_pulses;
    bit exp_active;
  } row_t;

  wr_t  exp_q[$];
  row_t rows[8];

  int chk_cnt = 0;
  int err_cnt = 0;
  int cyc_n = 0;
  int ack_delay = 0;
  int ctrlack_cnt = 0;
  int last_tick_cyc = -100;
  int ctrlinit_cyc = -100;
  int cfgack_cnt = 0;
  int pulse_cnt[N_CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [2:0] adr, input logic [31:0] dat);
    wr_t e;
    e.adr = adr;
    e.dat = dat;
    exp_q.push_back(e);
  endtask

  initial begin : cycle_counter
    forever begin
      @(posedge clock);
      cyc_n++;
    end
  end

  // PIT slave: acks after ack_delay wait cycles, checks each write against the scoreboard.
  initial begin : wb_slave
    int  wait_cnt;
    wr_t e;
    wait_cnt = 0;
    pit_ack = 1'b0;
    forever begin
      @(negedge clock);
      if (pit_ack) begin
        pit_ack = 1'b0;
        wait_cnt = 0;
      end else if (reset_n && pit_cyc && pit_stb) begin
        if (wait_cnt >= ack_delay) begin
          pit_ack = 1'b1;
          if (exp_q.size() == 0) begin
            chk_cnt++;
            err_cnt++;
            $display("FAIL unexpected_write: got adr %0h dat %0h, expected no write", pit_adr, pit_dat_w);
          end else begin
            e = exp_q.pop_front();
            check("wb_write", {pit_adr, pit_dat_w, pit_we, pit_sel}, {e.adr, e.dat, 1'b1, 4'hF});
          end
          if (pit_adr == 3'd0 && pit_dat_w == 32'h0000_000F) begin
            ctrlack_cnt++;
            last_tick_cyc = cyc_n;
          end
          if (pit_adr == 3'd0 && pit_dat_w == 32'h0000_000B) ctrlinit_cyc = cyc_n;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Expiry pulses must land two cycles after the CTRL_ACK ack (ack -> S_TICK -> pulse).
  initial begin : out_mon
    for (int i = 0; i < N_CH; i++) pulse_cnt[i] = 0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < N_CH; i++) begin
        if (ch_expire[i]) begin
          pulse_cnt[i]++;
          check($sformatf("expire_timing_ch%0d", i), cyc_n, last_tick_cyc + 2);
        end
      end
      if (cfg_ack) cfgack_cnt++;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic release_and_init();
    int k;
    k = 0;
    push_wr(3'd1, 32'd1000);
    push_wr(3'd0, 32'h0000_000B);
    @(negedge clock);
    reset_n = 1'b1;
    while (!ready && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("ready_rise", ready, 1);
    check("ready_timing", cyc_n, ctrlinit_cyc + 1);
    check("init_writes_done", exp_q.size(), 0);
  endtask

  task automatic load_ch(input int ch, input int period, input bit periodic);
    @(negedge clock);
    ch_load[ch]              = 1'b1;
    ch_period[ch*TW +: TW]   = TW'(period);
    ch_periodic[ch]          = periodic;
    @(negedge clock);
    ch_load = '0;
  endtask

  task automatic fire_irq();
    int n0;
    int k;
    n0 = ctrlack_cnt;
    k = 0;
    push_wr(3'd0, 32'h0000_000F);
    @(negedge clock);
    pit_irq = 1'b1;
    while (ctrlack_cnt == n0 && k < 100) begin
      @(posedge clock);
      #1;
      k++;
    end
    if (ctrlack_cnt == n0) check("irq_service", ctrlack_cnt, n0 + 1);
    pit_irq = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  initial begin : main
    int          k;
    int          n0;
    int          base;
    int          hi;
    int          tick_base;
    bit          held;
    logic [2:0]  a0;
    logic [31:0] d0;

    reset_n     = 1'b0;
    pit_dat_r   = '0;
    pit_irq     = 1'b0;
    cfg_req     = 1'b0;
    cfg_mod     = '0;
    ch_load     = '0;
    ch_period   = '0;
    ch_periodic = '0;
    tick_base   = 0;

    rows[0] = '{0, 3, 1'b0, 3, 1, 1'b0};
    rows[1] = '{1, 2, 1'b1, 6, 3, 1'b1};
    rows[2] = '{1, 0, 1'b0, 2, 0, 1'b0};
    rows[3] = '{3, 1, 1'b0, 1, 1, 1'b0};
    rows[4] = '{2, 0, 1'b0, 2, 0, 1'b0};
    rows[5] = '{2, 1, 1'b1, 3, 3, 1'b1};
    rows[6] = '{3, 4, 1'b0, 2, 0, 1'b1};
    rows[7] = '{3, 0, 1'b0, 5, 0, 1'b0};

    repeat (3) @(negedge clock);
    check("reset_outputs", {pit_cyc, pit_stb, pit_we, pit_sel, pit_adr, pit_dat_w,
                            cfg_ack, ready, ch_active, ch_expire}, '0);
    release_and_init();

    // Channel table.
    for (int r = 0; r < 8; r++) begin
      base = pulse_cnt[rows[r].ch];
      load_ch(rows[r].ch, rows[r].period, rows[r].periodic);
      for (int n = 0; n < rows[r].n_irq; n++) fire_irq();
      check($sformatf("row%0d_pulses", r), pulse_cnt[rows[r].ch] - base, rows[r].exp_pulses);
      check($sformatf("row%0d_active", r), ch_active[rows[r].ch], rows[r].exp_active);
    end

    // Load during S_TICK: new period taken, no decrement that tick.
    load_ch(2, 5, 1'b0);
    base = pulse_cnt[2];
    n0 = ctrlack_cnt;
    k = 0;
    push_wr(3'd0, 32'h0000_000F);
    @(negedge clock);
    pit_irq = 1'b1;
    while (ctrlack_cnt == n0 && k < 100) begin
      @(posedge clock);
      #1;
      k++;
    end
    check("tick_load_service", ctrlack_cnt, n0 + 1);
    pit_irq = 1'b0;
    ch_load[2]             = 1'b1;
    ch_period[2*TW +: TW]  = 16'd2;
    ch_periodic[2]         = 1'b0;
    @(posedge clock);
    #1;
    ch_load = '0;
    repeat (3) @(negedge clock);
    check("tick_load_no_expire", pulse_cnt[2] - base, 0);
    check("tick_load_active", ch_active[2], 1);
    fire_irq();
    check("tick_load_after1", pulse_cnt[2] - base, 0);
    fire_irq();
    check("tick_load_after2", pulse_cnt[2] - base, 1);
    check("tick_load_done", ch_active[2], 0);

    // Ack stall: bus signals held for 5 wait cycles plus the ack cycle.
    ack_delay = 5;
    n0 = ctrlack_cnt;
    push_wr(3'd0, 32'h0000_000F);
    @(negedge clock);
    pit_irq = 1'b1;
    k = 0;
    while (!pit_cyc && k < 20) begin
      @(posedge clock);
      #1;
      k++;
    end
    held = 1'b1;
    hi = 0;
    a0 = pit_adr;
    d0 = pit_dat_w;
    while (pit_cyc && hi < 20) begin
      if (pit_adr != a0 || pit_dat_w != d0 || !pit_stb) held = 1'b0;
      hi++;
      @(posedge clock);
      #1;
    end
    check("stall_cyc_cycles", hi, 6);
    check("stall_held", held, 1);
    check("stall_single_write", ctrlack_cnt, n0 + 1);
    pit_irq = 1'b0;
    ack_delay = 0;
    repeat (3) @(negedge clock);

    // IRQ and cfg_req together: IRQ service first, then modulo and control writes.
    n0 = cfgack_cnt;
    base = ctrlack_cnt;
    push_wr(3'd0, 32'h0000_000F);
    push_wr(3'd1, 32'd500);
    push_wr(3'd0, 32'h0000_000B);
    @(negedge clock);
    pit_irq = 1'b1;
    cfg_req = 1'b1;
    cfg_mod = 32'd500;
    k = 0;
    while (!cfg_ack && k < 100) begin
      @(negedge clock);
      k++;
      if (ctrlack_cnt != base) pit_irq = 1'b0;
    end
    check("cfg_ack_seen", cfg_ack, 1);
    check("cfg_ack_timing", cyc_n, ctrlinit_cyc + 1);
    cfg_req = 1'b0;
    cfg_mod = '0;
    repeat (4) @(negedge clock);
    check("cfg_ack_single", cfgack_cnt - n0, 1);
    check("cfg_writes_done", exp_q.size(), 0);
    check("cfg_ready_kept", ready, 1);

    // Reset in the middle of a stalled write.
    ack_delay = 10;
    @(negedge clock);
    pit_irq = 1'b1;
    k = 0;
    while (!pit_cyc && k < 20) begin
      @(posedge clock);
      #1;
      k++;
    end
    check("cyc_before_reset", pit_cyc, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_bus", {pit_cyc, pit_stb, pit_we, pit_sel, pit_adr, pit_dat_w}, '0);
    check("async_reset_outputs", {cfg_ack, ready, ch_active, ch_expire}, '0);
    pit_irq = 1'b0;
    ack_delay = 0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    tick_base = ctrlack_cnt;
    release_and_init();
    fire_irq();

`ifdef FWPIT_SCHED_TICKCNT_EN
    check("tick_count", tick_count, ctrlack_cnt - tick_base);
    check("tick_overrun", tick_overrun, 0);
`endif

    repeat (3) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
